// File: rtl/calc_pkg.sv
// Shared encodings for the calculator sequencer: key codes, ALU opcodes,
// FSM states and the pending-operator record used for operator chaining.
package calc_pkg;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_DIV = 4'hC;
    localparam logic [3:0] KEY_MUL = 4'hD;
    localparam logic [3:0] KEY_CLR = 4'hE;
    localparam logic [3:0] KEY_EQ  = 4'hF;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_DIV = 2'd2,
        OP_MUL = 2'd3
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_ENTRY_A,
        ST_OP_WAIT,
        ST_ENTRY_B,
        ST_ISSUE,
        ST_WAIT_ALU,
        ST_SHOW,
        ST_ERROR
    } state_e;

    // Operator typed while an operation was being issued; none = plain equals.
    typedef struct packed {
        logic    none;
        alu_op_e op;
    } pend_t;

    localparam pend_t PEND_NONE = '{none: 1'b1, op: OP_ADD};

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

    function automatic logic is_op(input logic [3:0] k);
        return (k >= KEY_ADD) && (k <= KEY_MUL);
    endfunction

    function automatic alu_op_e key_to_op(input logic [3:0] k);
        case (k)
            KEY_SUB: return OP_SUB;
            KEY_DIV: return OP_DIV;
            KEY_MUL: return OP_MUL;
            default: return OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/calc_digit_acc.sv
// Decimal operand accumulator: acc = acc*10 + d with a per-operand digit limit.
// clear has priority over load (acc = d), which has priority over shift.
module calc_digit_acc #(
    parameter int WIDTH      = 32,
    parameter int MAX_DIGITS = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic             shift,
    input  logic [3:0]       digit,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] acc_shifted
);

    localparam int CW = $clog2(MAX_DIGITS + 1);

    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic [WIDTH-1:0] acc_nxt;
    logic             room;

    assign room        = count < CW'(MAX_DIGITS);
    assign acc_shifted = room ? (acc * WIDTH'(10) + WIDTH'(digit)) : acc;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        acc_nxt   = acc;
        count_nxt = count;
        if (clear) begin
            acc_nxt   = '0;
            count_nxt = '0;
        end else if (load) begin
            acc_nxt   = WIDTH'(digit);
            count_nxt = CW'(1);
        end else if (shift && room) begin
            acc_nxt   = acc_shifted;
            count_nxt = count + CW'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc   <= '0;
            count <= '0;
        end else begin
            acc   <= acc_nxt;
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/calc_op_sequencer.sv
// Calculator sequencer: turns keypad events into operands, issues operations to
// the shared multi-cycle ALU over start/done, and drives the display value.
module calc_op_sequencer
    import calc_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter int               MAX_DIGITS = 9,
    parameter int               TIMEOUT    = 64,
    parameter logic [WIDTH-1:0] ERR_CODE   = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    output logic             key_ready,
    output logic             alu_start,
    output logic [1:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic             alu_done,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_err,
    output logic [WIDTH-1:0] display,
    output logic             disp_err
);

    localparam int TW = $clog2(TIMEOUT);

    state_e           state, state_nxt;
    logic [WIDTH-1:0] a_reg, a_nxt;
    logic [WIDTH-1:0] disp_nxt;
    logic             err_nxt;
    alu_op_e          op_reg, op_nxt;
    pend_t            pend, pend_nxt;
    logic [WIDTH-1:0] alu_a_nxt, alu_b_nxt;
    alu_op_e          alu_op_q, alu_op_nxt;
    logic             start_nxt;
    logic [TW-1:0]    timer, timer_nxt;

    logic             acc_clear, acc_load, acc_shift;
    logic [WIDTH-1:0] acc, acc_shifted;
    logic             key_fire;

    calc_digit_acc #(
        .WIDTH      (WIDTH),
        .MAX_DIGITS (MAX_DIGITS)
    ) u_digit_acc (
        .clk         (clk),
        .reset       (reset),
        .clear       (acc_clear),
        .load        (acc_load),
        .shift       (acc_shift),
        .digit       (key_code),
        .acc         (acc),
        .acc_shifted (acc_shifted)
    );

    assign key_ready = (state != ST_ISSUE) && (state != ST_WAIT_ALU);
    assign key_fire  = key_valid && key_ready;
    assign alu_op    = alu_op_q;

    always_comb begin
        state_nxt  = state;
        a_nxt      = a_reg;
        disp_nxt   = display;
        err_nxt    = disp_err;
        op_nxt     = op_reg;
        pend_nxt   = pend;
        alu_a_nxt  = alu_a;
        alu_b_nxt  = alu_b;
        alu_op_nxt = alu_op_q;
        start_nxt  = 1'b0;
        timer_nxt  = timer;
        acc_clear  = 1'b0;
        acc_load   = 1'b0;
        acc_shift  = 1'b0;

        if (key_fire && key_code == KEY_CLR) begin
            acc_clear = 1'b1;
            a_nxt     = '0;
            disp_nxt  = '0;
            err_nxt   = 1'b0;
            state_nxt = ST_ENTRY_A;
        end else begin
            unique case (state)
                ST_ENTRY_A: if (key_fire) begin
                    if (is_digit(key_code)) begin
                        acc_shift = 1'b1;
                        disp_nxt  = acc_shifted;
                    end else if (is_op(key_code)) begin
                        a_nxt     = acc;
                        op_nxt    = key_to_op(key_code);
                        state_nxt = ST_OP_WAIT;
                    end
                end
                ST_OP_WAIT: if (key_fire) begin
                    if (is_digit(key_code)) begin
                        acc_load  = 1'b1;
                        state_nxt = ST_ENTRY_B;
                    end else if (is_op(key_code)) begin
                        op_nxt = key_to_op(key_code);
                    end
                end
                ST_ENTRY_B: if (key_fire) begin
                    if (is_digit(key_code)) begin
                        acc_shift = 1'b1;
                        disp_nxt  = acc_shifted;
                    end else if (is_op(key_code)) begin
                        pend_nxt  = '{none: 1'b0, op: key_to_op(key_code)};
                        state_nxt = ST_ISSUE;
                    end else if (key_code == KEY_EQ) begin
                        pend_nxt  = PEND_NONE;
                        state_nxt = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Divide by zero never reaches the ALU.
                    if (op_reg == OP_DIV && acc == '0) begin
                        disp_nxt  = ERR_CODE;
                        err_nxt   = 1'b1;
                        state_nxt = ST_ERROR;
                    end else begin
                        alu_a_nxt  = a_reg;
                        alu_b_nxt  = acc;
                        alu_op_nxt = op_reg;
                        start_nxt  = 1'b1;
                        timer_nxt  = '0;
                        state_nxt  = ST_WAIT_ALU;
                    end
                end
                ST_WAIT_ALU: begin
                    if (alu_done && !alu_err) begin
                        disp_nxt = alu_result;
                        a_nxt    = alu_result;
                        if (pend.none) begin
                            state_nxt = ST_SHOW;
                        end else begin
                            op_nxt    = pend.op;
                            state_nxt = ST_OP_WAIT;
                        end
                    end else if (alu_done || timer == TW'(TIMEOUT - 1)) begin
                        disp_nxt  = ERR_CODE;
                        err_nxt   = 1'b1;
                        state_nxt = ST_ERROR;
                    end else begin
                        timer_nxt = timer + TW'(1);
                    end
                end
                ST_SHOW: if (key_fire) begin
                    if (is_digit(key_code)) begin
                        acc_load  = 1'b1;
                        state_nxt = ST_ENTRY_A;
                    end else if (is_op(key_code)) begin
                        a_nxt     = display;
                        op_nxt    = key_to_op(key_code);
                        state_nxt = ST_OP_WAIT;
                    end
                end
                ST_ERROR: ;
                default: state_nxt = ST_ENTRY_A;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_ENTRY_A;
            a_reg     <= '0;
            display   <= '0;
            disp_err  <= 1'b0;
            op_reg    <= OP_ADD;
            pend      <= PEND_NONE;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op_q  <= OP_ADD;
            alu_start <= 1'b0;
            timer     <= '0;
        end else begin
            state     <= state_nxt;
            a_reg     <= a_nxt;
            display   <= disp_nxt;
            disp_err  <= err_nxt;
            op_reg    <= op_nxt;
            pend      <= pend_nxt;
            alu_a     <= alu_a_nxt;
            alu_b     <= alu_b_nxt;
            alu_op_q  <= alu_op_nxt;
            alu_start <= start_nxt;
            timer     <= timer_nxt;
        end
    end

endmodule
